jpeg_byte_mem_writer: RTL and testbench

- Sink for the JPEG encoder's compressed byte stream (je_valid/je_data/je_done).
- Writes each byte sequentially into a byte-wide image buffer RAM through a simple address/data/write-enable port.
- On end of stream, appends the EOI marker (0xFF 0xD9), then parks until reset.
- A small internal FIFO decouples encoder bursts from the write engine.

---
 rtl/jpeg_byte_mem_writer.sv | 178 +++++++++++++++++
 tb/tb_jpeg_byte_mem_writer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_byte_mem_writer.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_byte_mem_writer
// Description : Sink for the JPEG encoder byte stream. Buffers incoming bytes
//               in a small FIFO, writes them sequentially into a byte-wide
//               image RAM, appends the EOI marker (FF D9) at end of stream
//               and then parks until reset. Writes saturate at the top of
//               the buffer; the address never wraps.
//               Optional macro JDW_BYTE_STUFF_EN inserts a 0x00 write after
//               every stream byte equal to 0xFF.
// Revision    : 1.0 - initial release
// ============================================================================
module jpeg_byte_mem_writer #(
  parameter int ADDR_W  = 17,
  parameter int FIFO_AW = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              je_valid,
  input  logic [7:0]        je_data,
  input  logic              je_done,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data,
  output logic              we
);

  localparam int          c_DEPTH    = 1 << FIFO_AW;
  localparam logic [1:0]  c_ST_RUN   = 2'd0;
  localparam logic [1:0]  c_ST_EOI1  = 2'd1;
  localparam logic [1:0]  c_ST_EOI2  = 2'd2;
  localparam logic [1:0]  c_ST_DONE  = 2'd3;
  localparam logic [FIFO_AW:0]  c_PTR_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] c_ADDR_MAX = {ADDR_W{1'b1}};

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [7:0]        r_fifo [c_DEPTH];
  logic [FIFO_AW:0]  r_wr_ptr;
  logic [FIFO_AW:0]  r_rd_ptr;
  logic              r_done;
  logic [ADDR_W-1:0] r_wptr;
  logic              r_sat;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_wr;
  logic [7:0]        w_wr_data;
  logic [7:0]        w_head;
  logic              w_stuff_pend;

  // FIFO status; the extra pointer bit separates full from empty
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                   (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
  assign w_head  = r_fifo[r_rd_ptr[FIFO_AW-1:0]];
  // Bytes are accepted only while running and before the done flag; full drops
  assign w_push  = je_valid && (r_state == c_ST_RUN) && !r_done && !w_full;

`ifdef JDW_BYTE_STUFF_EN
  logic r_stuff;

  // Stuff request: armed by a 0xFF pop, consumed by the following cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stuff <= 1'b0;
    end else if (r_state == c_ST_RUN) begin
      if (r_stuff)
        r_stuff <= 1'b0;
      else if (w_pop && (w_head == 8'hFF) && !r_sat)
        r_stuff <= 1'b1;
    end
  end

  assign w_stuff_pend = r_stuff;
`else
  assign w_stuff_pend = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n)
      r_state <= c_ST_RUN;
    else
      r_state <= w_state_nxt;
  end

  // Next-state logic: leave RUN only once the stream is fully drained
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_RUN:  if (r_done && w_empty && !w_stuff_pend) w_state_nxt = c_ST_EOI1;
      c_ST_EOI1: w_state_nxt = c_ST_EOI2;
      c_ST_EOI2: w_state_nxt = c_ST_DONE;
      default:   w_state_nxt = c_ST_DONE;
    endcase
  end

  // Output logic: choose this cycle's write; saturation suppresses the strobe
  always_comb begin
    w_pop     = 1'b0;
    w_wr      = 1'b0;
    w_wr_data = 8'h00;
    case (r_state)
      c_ST_RUN: begin
        if (w_stuff_pend) begin
          w_wr      = !r_sat;
          w_wr_data = 8'h00;
        end else if (!w_empty) begin
          w_pop     = 1'b1;
          w_wr      = !r_sat;
          w_wr_data = w_head;
        end
      end
      c_ST_EOI1: begin
        w_wr      = !r_sat;
        w_wr_data = 8'hFF;
      end
      c_ST_EOI2: begin
        w_wr      = !r_sat;
        w_wr_data = 8'hD9;
      end
      default: begin
        w_wr      = 1'b0;
        w_wr_data = 8'h00;
      end
    endcase
  end

  // FIFO storage; contents need no reset because pointers gate reads
  always_ff @(posedge clk) begin
    if (w_push)
      r_fifo[r_wr_ptr[FIFO_AW-1:0]] <= je_data;
  end

  // FIFO pointers; reset flushes any buffered bytes
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
    end
  end

  // Done flag: a level on je_done while running latches end of stream
  always_ff @(posedge clk) begin
    if (!reset_n)
      r_done <= 1'b0;
    else if (je_done && (r_state == c_ST_RUN))
      r_done <= 1'b1;
  end

  // Memory port registers and write pointer; pointer stops at the top address
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr   <= '0;
      data   <= 8'h00;
      we     <= 1'b0;
      r_wptr <= '0;
      r_sat  <= 1'b0;
    end else begin
      we <= w_wr;
      if (w_wr) begin
        addr <= r_wptr;
        data <= w_wr_data;
        if (r_wptr == c_ADDR_MAX)
          r_sat <= 1'b1;
        else
          r_wptr <= r_wptr + c_ADDR_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jpeg_byte_mem_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_jpeg_byte_mem_writer
// Description : Self-checking bench for jpeg_byte_mem_writer. A full-size
//               instance and a 4-bit-address instance share the clock; the
//               expected memory image is built from the accepted byte stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jpeg_byte_mem_writer;

  logic        clk = 1'b0;
  logic        reset_n, je_valid, je_done;
  logic [7:0]  je_data;
  logic [16:0] addr;
  logic [7:0]  data;
  logic        we;

  logic        reset_n4, je_valid4, je_done4;
  logic [7:0]  je_data4;
  logic [3:0]  addr4;
  logic [7:0]  data4;
  logic        we4;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [16:0] wa_q [$];
  logic [7:0]  wd_q [$];
  int          wc_q [$];
  logic [3:0]  wa4_q [$];
  logic [7:0]  wd4_q [$];
  logic [7:0]  stream_q [$];
  logic [7:0]  exp_q [$];

  jpeg_byte_mem_writer #(.ADDR_W(17), .FIFO_AW(3)) dut (
    .clk(clk), .reset_n(reset_n), .je_valid(je_valid), .je_data(je_data),
    .je_done(je_done), .addr(addr), .data(data), .we(we));

  jpeg_byte_mem_writer #(.ADDR_W(4), .FIFO_AW(3)) dut4 (
    .clk(clk), .reset_n(reset_n4), .je_valid(je_valid4), .je_data(je_data4),
    .je_done(je_done4), .addr(addr4), .data(data4), .we(we4));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write log, sampled mid-cycle
  always @(negedge clk) begin
    if (we === 1'b1) begin
      wa_q.push_back(addr);
      wd_q.push_back(data);
      wc_q.push_back(cyc);
    end
    if (we4 === 1'b1) begin
      wa4_q.push_back(addr4);
      wd4_q.push_back(data4);
    end
  end

  // Expected image: stream (stuffed if enabled) + EOI, clipped at buffer size
  function automatic void build_expected(input int aw);
    exp_q = {};
    foreach (stream_q[i]) begin
      exp_q.push_back(stream_q[i]);
`ifdef JDW_BYTE_STUFF_EN
      if (stream_q[i] == 8'hFF) exp_q.push_back(8'h00);
`endif
    end
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD9);
    while (exp_q.size() > (1 << aw)) void'(exp_q.pop_back());
  endfunction

  task automatic clear_logs();
    wa_q = {}; wd_q = {}; wc_q = {}; wa4_q = {}; wd4_q = {};
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; je_valid = 1'b0; je_done = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    clear_logs();
  endtask

  task automatic wait_writes(input int n, input int budget);
    int k = 0;
    while (wa_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0; je_valid = 1'b0; je_done = 1'b0; je_data = 8'h00;
    @(negedge clk);
    n_checks++; if (we !== 1'b0) $display("FAIL reset_we: got %0b want 0", we); else n_pass++;
    n_checks++; if (addr !== 17'd0) $display("FAIL reset_addr: got %0h want 0", addr); else n_pass++;
    n_checks++; if (data !== 8'h00) $display("FAIL reset_data: got %0h want 0", data); else n_pass++;
    reset_n = 1'b1;
    clear_logs();
  endtask

  task automatic test_basic();
    int c0;
    logic [7:0] v [3];
    v[0] = 8'h11; v[1] = 8'h22; v[2] = 8'h33;
    do_reset();
    @(negedge clk);
    c0 = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      je_valid = 1'b1; je_data = v[i];
      @(negedge clk);
    end
    je_valid = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (wa_q.size() !== 3) $display("FAIL basic_count: got %0d want 3", wa_q.size());
    else begin
      n_pass++;
      for (int i = 0; i < 3; i++) begin
        n_checks++; if (wa_q[i] !== 17'(i)) $display("FAIL basic_addr%0d: got %0h want %0h", i, wa_q[i], i); else n_pass++;
        n_checks++; if (wd_q[i] !== v[i]) $display("FAIL basic_data%0d: got %0h want %0h", i, wd_q[i], v[i]); else n_pass++;
        n_checks++; if (wc_q[i] !== c0 + 1 + i) $display("FAIL basic_cycle%0d: got %0d want %0d", i, wc_q[i], c0 + 1 + i); else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    int cnt = 0;
    int bad_a = 0, bad_d = 0, n;
    do_reset();
    stream_q = {};
    while (cnt < 16383) begin
      @(negedge clk);
      je_data = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        je_valid = 1'b1;
        stream_q.push_back(je_data);
        cnt++;
      end else begin
        je_valid = 1'b0;
      end
    end
    @(negedge clk);
    je_valid = 1'b0; je_done = 1'b1;
    @(negedge clk);
    je_done = 1'b0;
    build_expected(17);
    wait_writes(exp_q.size(), 2000);
    n = (wa_q.size() < exp_q.size()) ? wa_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (wa_q[i] !== 17'(i)) bad_a++;
      if (wd_q[i] !== exp_q[i]) bad_d++;
    end
    n_checks++; if (wa_q.size() !== exp_q.size()) $display("FAIL rand_count: got %0d want %0d", wa_q.size(), exp_q.size()); else n_pass++;
    n_checks++; if (bad_a !== 0) $display("FAIL rand_addr: got %0d bad addresses want 0", bad_a); else n_pass++;
    n_checks++; if (bad_d !== 0) $display("FAIL rand_data: got %0d bad bytes want 0", bad_d); else n_pass++;
    n_checks++; if (we !== 1'b0) $display("FAIL rand_idle_we: got %0b want 0", we); else n_pass++;
  endtask

  task automatic test_done_same_cycle();
    int bad = 0, n;
    do_reset();
    stream_q = {};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      je_valid = 1'b1; je_data = 8'($urandom_range(0, 254));
      stream_q.push_back(je_data);
    end
    @(negedge clk);
    je_valid = 1'b1; je_data = 8'h44; je_done = 1'b1;
    stream_q.push_back(8'h44);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      je_done = 1'($urandom_range(0, 1));
      je_valid = 1'b1; je_data = 8'($urandom);
    end
    je_valid = 1'b0; je_done = 1'b0;
    build_expected(17);
    wait_writes(exp_q.size(), 100);
    n = (wa_q.size() < exp_q.size()) ? wa_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (wa_q[i] !== 17'(i) || wd_q[i] !== exp_q[i]) bad++;
    n_checks++; if (wa_q.size() !== 8) $display("FAIL done_count: got %0d want 8", wa_q.size()); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL done_image: got %0d bad writes want 0", bad); else n_pass++;
    n_checks++;
    if (wd_q.size() < 8) $display("FAIL done_byte44: got %0d writes want 8", wd_q.size());
    else if (wd_q[5] !== 8'h44 || wd_q[6] !== 8'hFF || wd_q[7] !== 8'hD9)
      $display("FAIL done_byte44: got %0h %0h %0h want 44 ff d9", wd_q[5], wd_q[6], wd_q[7]);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int k = 0, bad = 0, n;
    do_reset();
    while (wa_q.size() < 10 && k < 50) begin
      @(negedge clk);
      je_valid = 1'b1; je_data = 8'($urandom);
      k++;
    end
    reset_n = 1'b0; je_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (we !== 1'b0) $display("FAIL midrst_we: got %0b want 0", we); else n_pass++;
    n_checks++; if (addr !== 17'd0) $display("FAIL midrst_addr: got %0h want 0", addr); else n_pass++;
    reset_n = 1'b1;
    clear_logs();
    stream_q = {};
    for (int i = 0; i < 3; i++) begin
      je_valid = 1'b1; je_data = 8'($urandom);
      stream_q.push_back(je_data);
      @(negedge clk);
    end
    je_valid = 1'b0; je_done = 1'b1;
    @(negedge clk);
    je_done = 1'b0;
    build_expected(17);
    wait_writes(exp_q.size(), 100);
    n = (wa_q.size() < exp_q.size()) ? wa_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (wa_q[i] !== 17'(i) || wd_q[i] !== exp_q[i]) bad++;
    n_checks++; if (wa_q.size() !== exp_q.size()) $display("FAIL midrst_count: got %0d want %0d", wa_q.size(), exp_q.size()); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL midrst_image: got %0d bad writes want 0", bad); else n_pass++;
  endtask

  task automatic test_saturation();
    int bad = 0, n;
    @(negedge clk);
    reset_n4 = 1'b0;
    @(negedge clk);
    reset_n4 = 1'b1;
    clear_logs();
    stream_q = {};
    for (int i = 0; i < 20; i++) begin
      je_valid4 = 1'b1; je_data4 = 8'($urandom_range(0, 254));
      stream_q.push_back(je_data4);
      @(negedge clk);
    end
    je_valid4 = 1'b0; je_done4 = 1'b1;
    @(negedge clk);
    je_done4 = 1'b0;
    build_expected(4);
    repeat (60) @(negedge clk);
    n = (wa4_q.size() < exp_q.size()) ? wa4_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (wa4_q[i] !== 4'(i) || wd4_q[i] !== exp_q[i]) bad++;
    n_checks++; if (wa4_q.size() !== 16) $display("FAIL sat_count: got %0d want 16", wa4_q.size()); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL sat_image: got %0d bad writes want 0", bad); else n_pass++;
    n_checks++; if (we4 !== 1'b0) $display("FAIL sat_we: got %0b want 0", we4); else n_pass++;
    n_checks++; if (addr4 !== 4'hF || data4 !== stream_q[15]) $display("FAIL sat_hold: got %0h/%0h want f/%0h", addr4, data4, stream_q[15]); else n_pass++;
  endtask

  task automatic test_stuff();
    logic [7:0] v [3];
    logic [7:0] want [$];
    int bad = 0, n;
    v[0] = 8'hAB; v[1] = 8'hFF; v[2] = 8'hCD;
`ifdef JDW_BYTE_STUFF_EN
    want = {8'hAB, 8'hFF, 8'h00, 8'hCD, 8'hFF, 8'hD9};
`else
    want = {8'hAB, 8'hFF, 8'hCD, 8'hFF, 8'hD9};
`endif
    do_reset();
    for (int i = 0; i < 3; i++) begin
      je_valid = 1'b1; je_data = v[i];
      @(negedge clk);
    end
    je_valid = 1'b0; je_done = 1'b1;
    @(negedge clk);
    je_done = 1'b0;
    wait_writes(want.size(), 100);
    n = (wa_q.size() < want.size()) ? wa_q.size() : want.size();
    for (int i = 0; i < n; i++)
      if (wa_q[i] !== 17'(i) || wd_q[i] !== want[i]) bad++;
    n_checks++; if (wa_q.size() !== want.size()) $display("FAIL stuff_count: got %0d want %0d", wa_q.size(), want.size()); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL stuff_image: got %0d bad writes want 0", bad); else n_pass++;
  endtask

  initial begin
    reset_n = 1'b0; je_valid = 1'b0; je_done = 1'b0; je_data = 8'h00;
    reset_n4 = 1'b0; je_valid4 = 1'b0; je_done4 = 1'b0; je_data4 = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_done_same_cycle();
    test_mid_reset();
    test_saturation();
    test_stuff();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
